rr_3src_pkt_mux: RTL
====================

Name: rr_3src_pkt_mux

Overview:
- Client-side companion to the 3-request round-robin arbiter. Drives the arbiter's request0..2 and ce inputs and consumes its 2-bit grant.
- Forwards whole packets from three byte-stream sources onto one output stream, e.g. merging capture, status and reply streams toward the FTDI/SDRAM write path.
- Holds arbiter ce low while a packet is in flight, so the grant never changes mid-packet.
- Optionally cuts over-long packets to bound latency for the other sources.

Parameters:
- DW, 8: data width of every stream.
- MAX_BEATS, 0: maximum beats per grant. 0 means unlimited (release only on last).
- CNT_W, 16: width of the beat counter. Must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_valid  in  3  per-source valid; bit i is source i
- s_data  in  3*DW  per-source data; source i occupies [i*DW +: DW]
- s_last  in  3  per-source end-of-packet flag
- s_ready  out  3  per-source ready
- m_valid  out  1  merged output valid
- m_data  out  DW  merged output data
- m_last  out  1  merged end-of-packet
- m_ready  in  1  downstream ready
- arb_request  out  3  to arbiter request0/1/2
- arb_ce  out  1  to arbiter ce
- arb_grant  in  2  from arbiter grant
- cur_src  out  2  source currently owning the output (valid when busy)
- busy  out  1  high in XFER
- pkt_cut  out  1  one-cycle pulse when a grant is released by MAX_BEATS rather than by last

Behaviour:
- Reset values: state=IDLE, sel=0, beat_cnt=0, pkt_cut=0. Consequently s_ready=0, m_valid=0, m_last=0, busy=0, cur_src=0.
- arb_request = s_valid in every state, combinational.
- arb_ce = 1 only in IDLE (Moore output).
- State IDLE:
  - arb_ce=1; arbiter may re-point grant on each edge.
  - If any s_valid is set → CHECK, else stay in IDLE.
- State CHECK:
  - arb_ce=0.
  - If arb_grant<=2 and s_valid[arb_grant]=1: latch sel<=arb_grant, beat_cnt<=0, → XFER.
  - Otherwise (grant=3, or the granted source dropped valid): → IDLE.
- State XFER:
  - arb_ce=0. Pure combinational pass-through from source sel:
    - m_valid = s_valid[sel], m_data = s_data[sel], m_last = s_last[sel]
    - s_ready[sel] = m_ready; the other s_ready bits are 0.
  - A beat is accepted when m_valid & m_ready. On each accepted beat, beat_cnt increments.
  - Accepted beat with s_last=1 → IDLE.
  - Else, if MAX_BEATS≠0 and beat_cnt==MAX_BEATS-1 on an accepted beat → IDLE and pulse pkt_cut for one cycle.
  - If s_last and the limit coincide on the same beat, the exit counts as a normal end: pkt_cut=0.
  - s_valid[sel] low in XFER: stall and stay in XFER. The packet is never abandoned.
- busy = (state==XFER); cur_src = sel.
- Latency: source valid at cycle 0 (IDLE) → CHECK at cycle 1 → first beat can be accepted at cycle 2. Back-to-back packets pay the same 2 idle cycles.
- Fairness comes from the arbiter only. The mux never overrides grant.
- Width rules:
  - beat_cnt saturates at all-ones; it never wraps.
  - arb_grant=3 is treated as no grant.
- Reset mid-packet: immediate return to IDLE. All ready/valid outputs go 0 asynchronously. The partial packet is the source's problem.

Decomposition:
- Shared package (rr_pkg):
  - state encoding constants IDLE=0, CHECK=1, XFER=2
  - NO_GRANT=2'd3
  - source count constant NSRC=3
- One natural sub-module: rr_src_sel, a combinational 3:1 selector for data/valid/last plus ready demux, indexed by sel.
- FSM and counters stay in the top module.
- Benches instantiate this block together with the round-robin arbiter.

Test Plan:
- Single source: src1 sends a 4-beat packet, m_ready=1 → arbiter grant goes to 1. First m_valid at cycle 2. 4 beats out with m_last on beat 4. Returns to IDLE with arb_ce=1.
- Contention: all three sources each hold a 2-beat packet, grant=0 after reset → output order src1, src2, src0. No interleaving of beats between packets.
- Backpressure: m_ready toggles 1,0,1,0 during a 3-beat src2 packet → s_ready[2] mirrors m_ready. Data stable while stalled. arb_ce stays 0 throughout.
- MAX_BEATS=3: src0 sends 5 beats while src1 is pending → after beat 3, pkt_cut pulses and src1 gets the next grant. src0's remaining 2 beats follow later.
- Granted source drops valid: grant moves to 2, then s_valid[2] falls in CHECK → return to IDLE, no beat emitted, m_valid stays 0.
- Async reset mid-XFER: rst_n low while in XFER → s_ready=0, m_valid=0 in the same cycle. After release, state=IDLE, beat_cnt=0.

Source files
------------

// File: rtl/rr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pkg: shared encodings for the 3-source round-robin packet mux.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rr_pkg;

  localparam int NSRC = 3;
  localparam logic [1:0] NO_GRANT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    XFER  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_src_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_src_sel: combinational 3:1 stream selector with ready demux.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_src_sel
  import rr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 en,
  input  logic [1:0]           sel,
  input  logic [NSRC-1:0]      s_valid,
  input  logic [NSRC*DW-1:0]   s_data,
  input  logic [NSRC-1:0]      s_last,
  output logic [NSRC-1:0]      s_ready,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  output logic                 m_last,
  input  logic                 m_ready
);

  // Outputs are held at zero unless a packet owns the path.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    s_ready = '0;
    if (en) begin
      for (int i = 0; i < NSRC; i++) begin
        if (sel == 2'(i)) begin
          m_valid    = s_valid[i];
          m_data     = s_data[i*DW +: DW];
          m_last     = s_last[i];
          s_ready[i] = m_ready;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_3src_pkt_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_3src_pkt_mux: packet-granular merge of three byte streams,      |
// | driving an external round-robin arbiter. Revision: 1.0             |
// +--------------------------------------------------------------------+
module rr_3src_pkt_mux
  import rr_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      s_valid,
  input  logic [NSRC*DW-1:0]   s_data,
  input  logic [NSRC-1:0]      s_last,
  output logic [NSRC-1:0]      s_ready,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [NSRC-1:0]      arb_request,
  output logic                 arb_ce,
  input  logic [1:0]           arb_grant,
  output logic [1:0]           cur_src,
  output logic                 busy,
  output logic                 pkt_cut
);

  // With MAX_BEATS=0 this wraps to all-ones but is never consulted.
  localparam logic [CNT_W-1:0] c_beat_limit = CNT_W'(MAX_BEATS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_pkt_cut;
  logic             w_cut;
  logic             w_grant_valid;
  logic             w_grant_ok;
  logic             w_accept;
  logic             w_limit;

  rr_src_sel #(
    .DW (DW)
  ) u_src_sel (
    .en      (r_state == XFER),
    .sel     (r_sel),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready)
  );

  always_comb begin
    w_grant_valid = 1'b0;
    case (arb_grant)
      2'd0:    w_grant_valid = s_valid[0];
      2'd1:    w_grant_valid = s_valid[1];
      2'd2:    w_grant_valid = s_valid[2];
      default: w_grant_valid = 1'b0;
    endcase
  end

  assign w_grant_ok = (arb_grant != NO_GRANT) && w_grant_valid;
  assign w_accept   = m_valid & m_ready;
  assign w_limit    = (MAX_BEATS != 0) && (r_beat_cnt == c_beat_limit);

  always_comb begin
    w_state_nxt = r_state;
    w_cut       = 1'b0;
    case (r_state)
      IDLE:  if (|s_valid) w_state_nxt = CHECK;
      CHECK: w_state_nxt = w_grant_ok ? XFER : IDLE;
      XFER: begin
        // A genuine end-of-packet takes precedence over the beat limit.
        if (w_accept) begin
          if (m_last) begin
            w_state_nxt = IDLE;
          end else if (w_limit) begin
            w_state_nxt = IDLE;
            w_cut       = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_pkt_cut  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pkt_cut <= w_cut;
      if (r_state == CHECK && w_grant_ok) begin
        r_sel      <= arb_grant;
        r_beat_cnt <= '0;
      end else if (w_accept && (r_beat_cnt != {CNT_W{1'b1}})) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign arb_request = s_valid;
  assign arb_ce      = (r_state == IDLE);
  assign busy        = (r_state == XFER);
  assign cur_src     = r_sel;
  assign pkt_cut     = r_pkt_cut;

endmodule
`default_nettype wire
